// File: rtl/pipe_arith_hs.sv
// 3-stage F = ((A+B) op (C-D)) * D with valid/ready; 3-cycle latency, 1 beat/cycle, holds up to 3 beats under backpressure.
// Define PIPE_ARITH_CNT_EN to add the 16-bit res_cnt output-transfer counter.
module pipe_arith_hs #(
  parameter int N = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [N-1:0]     C,
  input  logic [N-1:0]     D,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   F
`ifdef PIPE_ARITH_CNT_EN
  ,
  output logic [15:0]      res_cnt
`endif
);

  localparam int OUTW = 2 * N;

  logic            v1_q, v1_d, m1_q, m1_d;
  logic [N-1:0]    x1_q, x1_d, x2_q, x2_d, d1_q, d1_d;
  logic            v2_q, v2_d;
  logic [N-1:0]    x3_q, x3_d, d2_q, d2_d;
  logic            v3_q, v3_d;
  logic [OUTW-1:0] f_q, f_d;
  logic            ready1, ready2, ready3;
  logic [OUTW-1:0] prod;

  assign ready3    = !v3_q || out_ready;
  assign ready2    = !v2_q || ready3;
  assign ready1    = !v1_q || ready2;
  assign in_ready  = ready1;
  assign out_valid = v3_q;
  assign F         = f_q;

  // Zero-extend both factors so the product keeps all 2N bits.
  assign prod = {{N{1'b0}}, x3_q} * {{N{1'b0}}, d2_q};

  always_comb begin
    v1_d = v1_q;
    x1_d = x1_q;
    x2_d = x2_q;
    d1_d = d1_q;
    m1_d = m1_q;
    v2_d = v2_q;
    x3_d = x3_q;
    d2_d = d2_q;
    v3_d = v3_q;
    f_d  = f_q;
    if (ready1) begin
      v1_d = in_valid;
      x1_d = A + B;
      x2_d = C - D;
      d1_d = D;
      m1_d = mode;
    end
    if (ready2) begin
      v2_d = v1_q;
      x3_d = m1_q ? (x1_q - x2_q) : (x1_q + x2_q);
      d2_d = d1_q;
    end
    if (ready3) begin
      v3_d = v2_q;
      f_d  = prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      x1_q <= '0;
      x2_q <= '0;
      d1_q <= '0;
      m1_q <= 1'b0;
      v2_q <= 1'b0;
      x3_q <= '0;
      d2_q <= '0;
      v3_q <= 1'b0;
      f_q  <= '0;
    end else begin
      v1_q <= v1_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
      d1_q <= d1_d;
      m1_q <= m1_d;
      v2_q <= v2_d;
      x3_q <= x3_d;
      d2_q <= d2_d;
      v3_q <= v3_d;
      f_q  <= f_d;
    end
  end

`ifdef PIPE_ARITH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (v3_q && out_ready) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign res_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_arith_hs.sv
// Bench for pipe_arith_hs: vector table, backpressure/reset sequences and random traffic against a queue model.
module tb_pipe_arith_hs;
  localparam int N = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   A = '0, B = '0, C = '0, D = '0;
  logic           mode = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*N-1:0] F;
`ifdef PIPE_ARITH_CNT_EN
  logic [15:0]    res_cnt;
`endif

  pipe_arith_hs #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .D(D), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .F(F)
`ifdef PIPE_ARITH_CNT_EN
    , .res_cnt(res_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint expq[$];
  longint got[$];

  typedef struct {
    int unsigned a, b, c, d;
    bit          m;
    longint      f;
  } vec_t;

  function automatic longint ref_f(int unsigned a, int unsigned b, int unsigned c,
                                   int unsigned d, bit m);
    longint md = longint'(1) << N;
    longint x1 = (a + b) % md;
    longint x2 = (c + md - d) % md;
    longint x3 = m ? (x1 + md - x2) % md : (x1 + x2) % md;
    return x3 * d;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock: inputs must already be settled; records both handshakes at this edge.
  task automatic tick();
    bit infire, outfire;
    infire  = in_valid && in_ready;
    outfire = out_valid && out_ready;
    if (outfire) begin
      got.push_back(longint'(F));
      if (expq.size() == 0) check("sb_unexpected_output", longint'(F), -1);
      else check("sb_result", longint'(F), expq.pop_front());
    end
    if (infire) expq.push_back(ref_f(A, B, C, D, mode));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int unsigned a, input int unsigned b,
                       input int unsigned c, input int unsigned d, input bit m, input bit ordy);
    in_valid  = v;
    A = a[N-1:0]; B = b[N-1:0]; C = c[N-1:0]; D = d[N-1:0];
    mode      = m;
    out_ready = ordy;
    #1;
  endtask

  vec_t vt[5];
  longint bp_exp[6];

  initial begin
    vt[0] = '{a: 5,    b: 3,    c: 10,   d: 4,    m: 1'b0, f: 56};
    vt[1] = '{a: 5,    b: 3,    c: 10,   d: 4,    m: 1'b1, f: 8};
    vt[2] = '{a: 1023, b: 1,    c: 0,    d: 1,    m: 1'b0, f: 1023};
    vt[3] = '{a: 1023, b: 1023, c: 1023, d: 1023, m: 1'b0, f: 1045506};
    vt[4] = '{a: 0,    b: 0,    c: 0,    d: 1023, m: 1'b1, f: 1046529};
    bp_exp = '{1023, 2044, 3063, 4080, 5095, 6108};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_F", longint'(F), 0);
    check("reset_in_ready", longint'(in_ready), 1);
`ifdef PIPE_ARITH_CNT_EN
    check("reset_res_cnt", longint'(res_cnt), 0);
`endif

    // Single-beat vectors: latency and value
    foreach (vt[i]) begin
      drive(1'b1, vt[i].a, vt[i].b, vt[i].c, vt[i].d, vt[i].m, 1'b1);
      check($sformatf("vec%0d_in_ready", i), longint'(in_ready), 1);
      tick();
      check($sformatf("vec%0d_valid_c1", i), longint'(out_valid), 0);
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      tick();
      check($sformatf("vec%0d_valid_c2", i), longint'(out_valid), 0);
      tick();
      check($sformatf("vec%0d_valid_c3", i), longint'(out_valid), 1);
      check($sformatf("vec%0d_F", i), longint'(F), vt[i].f);
      tick();
      check($sformatf("vec%0d_valid_c4", i), longint'(out_valid), 0);
    end

    // Backpressure: 6 beats, consumer stalled for the first 8 cycles
    begin
      int     sent = 0;
      int     acc_at_low = -1;
      bit     stalled;
      longint held;
      got.delete();
      for (int c = 1; c <= 60 && got.size() < 6; c++) begin
        drive(sent < 6, 0, 0, 0, sent + 1, 1'b0, c > 8);
        if (!in_ready && acc_at_low < 0) acc_at_low = sent;
        stalled = out_valid && !out_ready;
        held    = longint'(F);
        if (in_valid && in_ready) sent++;
        tick();
        if (stalled) begin
          check("bp_valid_held", longint'(out_valid), 1);
          check("bp_F_held", longint'(F), held);
        end
      end
      check("bp_in_ready_fall_after", acc_at_low, 3);
      check("bp_result_count", got.size(), 6);
      for (int i = 0; i < 6; i++)
        check($sformatf("bp_result%0d", i), (i < got.size()) ? got[i] : -1, bp_exp[i]);
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      tick();
    end

    // Reset mid-stream, with a beat offered during reset
    begin
      bit saw = 1'b0;
      drive(1'b1, 7, 8, 9, 3, 1'b0, 1'b1);
      tick();
      tick();
      rst = 1'b1;
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expq.delete();
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_F", longint'(F), 0);
      check("midrst_in_ready", longint'(in_ready), 1);
      for (int i = 0; i < 6; i++) begin
        tick();
        if (out_valid) saw = 1'b1;
      end
      check("midrst_no_stale_output", longint'(saw), 0);
    end

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1023), $urandom_range(0, 1023),
            $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) != 0);
      tick();
    end
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 10 && expq.size() > 0; i++) tick();
    check("drain_empty", expq.size(), 0);

`ifdef PIPE_ARITH_CNT_EN
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    check("cnt_after_rst", longint'(res_cnt), 0);
    begin
      int outs = 0;
      for (int i = 0; i < 70100 && outs < 70000; i++) begin
        drive(1'b1, i, 1, 2, 3, 1'b0, 1'b1);
        if (out_valid && out_ready) outs++;
        tick();
      end
      check("cnt_transfers", outs, 70000);
      check("cnt_wrap", longint'(res_cnt), 4464);
    end
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    check("cnt_cleared", longint'(res_cnt), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
